muldiv_seq: RTL and testbench

// - Multi-cycle sequencer and iterative datapath for the RV32M multiply/divide operations, decoded by funct3.
// - Sits beside the ALU in EX. It accepts one operation, raises stall to the pipeline while busy, and returns the result with a one-cycle done pulse.
// - Operands are converted to magnitudes, iterated one bit per cycle, then sign-corrected in a final fix-up cycle.

---
 rtl/muldiv_seq.sv | 156 +++++++++++++++
 tb/tb_muldiv_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Iterative RV32M multiply/divide unit with pipeline stall/kill.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              C_CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] C_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_f3;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [XLEN-1:0]    r_acc;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_mag;
    logic [C_CNT_W-1:0] r_count;

    logic               w_is_div;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_div0;
    logic               w_ovf;
    logic [XLEN-1:0]    w_special;
    logic [XLEN:0]      w_mul_sum;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_diff;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_quot;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_fix_res;

    // Signedness per op: multiplies treat a as signed except MULHU, b only for MUL/MULH.
    assign w_is_div  = funct3[2];
    assign w_sign_a  = op_a[XLEN-1] & (w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11));
    assign w_sign_b  = op_b[XLEN-1] & (w_is_div ? ~funct3[0] : ~funct3[1]);
    assign w_mag_a   = w_sign_a ? -op_a : op_a;
    assign w_mag_b   = w_sign_b ? -op_b : op_b;
    assign w_div0    = w_is_div & (op_b == '0);
    assign w_ovf     = w_is_div & ~funct3[0] & (op_a == C_MIN) & (&op_b);
    assign w_special = w_div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);

    // Multiply: r_lo holds the multiplier, r_mag the multiplicand.
    assign w_mul_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_mag} : '0);
    // Divide: r_lo holds the dividend/quotient, r_acc the partial remainder.
    assign w_shift   = {r_acc, r_lo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_mag};

    assign w_prod    = (r_sign_a ^ r_sign_b) ? -{r_acc, r_lo} : {r_acc, r_lo};
    assign w_quot    = (r_sign_a ^ r_sign_b) ? -r_lo : r_lo;
    assign w_rem     = r_sign_a ? -r_acc : r_acc;

    always_comb begin
        w_fix_res = w_prod[XLEN-1:0];
        case (r_f3)
            3'b000:                 w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quot;
            default:                w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_f3     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_mag    <= '0;
            r_count  <= '0;
            result   <= '0;
        end else if (kill) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_div0 | w_ovf) begin
                            result  <= w_special;
                            r_state <= DONE;
                        end else begin
                            r_f3     <= funct3;
                            r_sign_a <= w_sign_a;
                            r_sign_b <= w_sign_b;
                            r_acc    <= '0;
                            r_lo     <= w_is_div ? w_mag_a : w_mag_b;
                            r_mag    <= w_is_div ? w_mag_b : w_mag_a;
                            r_count  <= C_CNT_W'(XLEN);
                            r_state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (r_f3[2]) begin
                        if (!w_diff[XLEN]) begin
                            r_acc <= w_diff[XLEN-1:0];
                            r_lo  <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_acc <= w_shift[XLEN-1:0];
                            r_lo  <= {r_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        {r_acc, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
                    end
                    r_count <= r_count - 1'b1;
                    if (r_count == C_CNT_W'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    result  <= w_fix_res;
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = (r_state == CALC) || (r_state == FIX);
    assign done  = (r_state == DONE);
    assign stall = busy | (start & (r_state == IDLE));

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Self-checking bench for muldiv_seq against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        kill = 1'b0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .kill   (kill),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit and integer arithmetic.
    function automatic void ref_model(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output bit special);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        int          sa;
        int          sb;
        bit          ovf;
        sa      = $signed(a);
        sb      = $signed(b);
        ovf     = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea      = (f3 == 3'd3) ? {32'h0, a} : {{32{a[31]}}, a};
        eb      = (f3 == 3'd0 || f3 == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p       = ea * eb;
        special = 1'b0;
        r       = '0;
        case (f3)
            3'd0: r = p[31:0];
            3'd1, 3'd2, 3'd3: r = p[63:32];
            3'd4: begin
                special = (b == 0) || ovf;
                r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            end
            3'd5: begin
                special = (b == 0);
                r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            end
            3'd6: begin
                special = (b == 0) || ovf;
                r = (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            end
            default: begin
                special = (b == 0);
                r = (b == 0) ? a : a % b;
            end
        endcase
    endfunction

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] got);
        logic [31:0] exp;
        bit          special;
        bit          stall_ok;
        int          lat;
        ref_model(f3, a, b, exp, special);
        @(negedge clk);
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        #1;
        stall_ok = (stall === 1'b1);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency f3=%0d", f3), lat, special ? 32'd1 : 32'd34);
        chk($sformatf("result f3=%0d a=%h b=%h", f3, a, b), result, exp);
        chk("stall_through_op", {31'b0, stall_ok & ~stall}, 32'd1);
        got = result;
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    logic [31:0] r;
    logic [31:0] old;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, r);          chk("mul_7x-3", r, 32'hFFFF_FFEB);
        do_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, r);  chk("mulh", r, 32'h0000_0000);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, r);  chk("mulhsu", r, 32'h8000_0000);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, r);  chk("mulhu", r, 32'h7FFF_FFFF);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, r);          chk("div_-7/2", r, 32'hFFFF_FFFD);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, r);          chk("rem_-7/2", r, 32'hFFFF_FFFF);
        do_op(3'd5, 32'hFFFF_FFFF, 32'd16, r);         chk("divu", r, 32'h0FFF_FFFF);
        do_op(3'd4, 32'h1234, 32'd0, r);               chk("div_by_0", r, 32'hFFFF_FFFF);
        do_op(3'd7, 32'h1234, 32'd0, r);               chk("remu_by_0", r, 32'h1234);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r);  chk("div_ovf", r, 32'h8000_0000);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r);  chk("rem_ovf", r, 32'h0);

        // Abort a multiply in its tenth CALC cycle, then restart right away.
        do_op(3'd0, 32'd11, 32'd3, old);
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd5; op_b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", {31'b0, busy}, 32'd0);
        chk("kill_done", {31'b0, done}, 32'd0);
        chk("kill_result_held", result, old);
        do_op(3'd0, 32'd7, 32'd6, r);                  chk("after_kill", r, 32'd42);

        // kill wins over start in IDLE
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("kill_prio_busy", {31'b0, busy}, 32'd0);
        chk("kill_prio_result", result, 32'd42);

        for (int i = 0; i < 200; i++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'h0;
            else if (sel == 1) b = 32'hFFFF_FFFF;
            else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 3) b = 32'($urandom_range(1, 20));
            do_op(f, a, b, r);
        end

        // Asynchronous reset in the middle of CALC
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, r);
        @(negedge clk);
        funct3 = 3'd1; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_done", {31'b0, done}, 32'd0);
        chk("async_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(3'd5, 32'd100, 32'd7, r);                chk("after_rst", r, 32'd14);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
